// File: rtl/rf_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// rf_writeback_arbiter
//
// Write-side front end of the integer register file. Two writeback producers
// share the single register-file write port:
//   src0 : single-cycle ALU path
//   src1 : long-latency LSU/MDU path
// When both are valid in the same cycle, they are granted round-robin. The
// accepted request goes through one registered stage onto rf_we/rf_waddr/
// rf_wdata. A per-register pending scoreboard lets the issue stage stall on
// RAW/WAW hazards, because the register file does no bypassing.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   src0_valid/rd/data      ALU writeback request; src0_ready = accepted
//   src1_valid/rd/data      LSU/MDU writeback request; src1_ready = accepted
//   issue_valid, issue_rd   destination of an issuing instruction (sets pend)
//   chk_rs1/rs2/rd          issue-stage registers to check
//   busy_rs1/rs2/rd         pending-write status of the checked registers
//   rf_we/rf_waddr/rf_wdata register-file write port (registered)
// ---------------------------------------------------------------------------
module rf_writeback_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            src0_valid,
  output logic            src0_ready,
  input  logic [4:0]      src0_rd,
  input  logic [XLEN-1:0] src0_data,

  input  logic            src1_valid,
  output logic            src1_ready,
  input  logic [4:0]      src1_rd,
  input  logic [XLEN-1:0] src1_data,

  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,

  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            busy_rd,

  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  // last_q holds the index of the source that won the most recent contested
  // cycle. It resets to 1 so that src0 wins the first contest.
  logic last_q, last_d;
  logic contested;
  logic grant0, grant1;

  always_comb begin
    contested = src0_valid & src1_valid;
    grant0    = src0_valid & (~src1_valid | last_q);
    grant1    = src1_valid & (~src0_valid | ~last_q);
    // The tie pointer moves only on contested cycles. An uncontested grant
    // does not count as a turn.
    last_d    = contested ? grant1 : last_q;
  end

  // The output stage drains every cycle, so a grant is always an acceptance.
  assign src0_ready = grant0;
  assign src1_ready = grant1;

  // -------------------------------------------------------------------------
  // Accepted request and output stage
  // -------------------------------------------------------------------------
  logic            acc_valid;
  logic [4:0]      acc_rd;
  logic [XLEN-1:0] acc_data;

  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  always_comb begin
    acc_valid = grant0 | grant1;
    acc_rd    = grant1 ? src1_rd   : src0_rd;
    acc_data  = grant1 ? src1_data : src0_data;

    // A write to x0 is acknowledged but never reaches the register file.
    we_d      = acc_valid & (acc_rd != 5'd0);
    // With no acceptance, address and data keep their last values.
    waddr_d   = acc_valid ? acc_rd   : waddr_q;
    wdata_d   = acc_valid ? acc_data : wdata_q;
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

  // -------------------------------------------------------------------------
  // Pending scoreboard
  // -------------------------------------------------------------------------
  logic [31:0] pend_q, pend_d;
  logic        issue_set;

  always_comb begin
    issue_set = issue_valid & (issue_rd != 5'd0);
    pend_d    = pend_q;
    // The clear happens on the edge that commits the write. From that edge
    // the register file already holds the new value, so readers need no
    // forwarding.
    if (we_q) begin
      pend_d[waddr_q] = 1'b0;
    end
    // A new issue to the same register on the same edge takes precedence
    // over the clear.
    if (issue_set) begin
      pend_d[issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // pend_q[0] is held at zero, so index 0 always reads as not busy.
  assign busy_rs1 = pend_q[chk_rs1];
  assign busy_rs2 = pend_q[chk_rs2];
  assign busy_rd  = pend_q[chk_rd];

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= '0;
      pend_q  <= 32'd0;
    end else begin
      last_q  <= last_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
    end
  end

endmodule
